// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared receiver state encoding and default frame constants.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int unsigned c_default_oversampling = 16;
  localparam int unsigned c_default_data_bits    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for a single asynchronous input bit.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_os16.sv
// ============================================================================
// Module  : uart_rx_os16
// Purpose : Oversampling UART receiver with optional parity and framing check.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = c_default_data_bits,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned OVERSAMPLING = c_default_oversampling
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned         c_cnt_w    = $clog2(OVERSAMPLING);
  localparam logic [c_cnt_w-1:0]  c_mid      = c_cnt_w'(OVERSAMPLING / 2 - 1);
  localparam logic [c_cnt_w-1:0]  c_last     = c_cnt_w'(OVERSAMPLING - 1);
  localparam logic [2:0]          c_last_bit = 3'(DATA_BITS - 1);
  localparam int unsigned         c_pad      = 8 - DATA_BITS;

  logic               w_rx;
  rx_state_t          r_state,    w_state_nxt;
  logic [c_cnt_w-1:0] r_tick_cnt, w_tick_nxt;
  logic [2:0]         r_bit_cnt,  w_bit_nxt;
  logic [7:0]         r_shreg,    w_shreg_nxt;
  logic               r_par_bad,  w_par_bad_nxt;
  logic [7:0]         r_rx_data,  w_data_nxt;
  logic               r_rx_valid, w_valid_nxt;
  logic               r_perr,     w_perr_nxt;
  logic               r_ferr,     w_ferr_nxt;
  logic [7:0]         w_word;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (w_rx)
  );

  // Bits enter at the MSB, so a short word ends up in the top bits.
  assign w_word = r_shreg >> c_pad;

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_par_bad_nxt = r_par_bad;
    w_data_nxt    = r_rx_data;
    w_valid_nxt   = 1'b0;
    w_perr_nxt    = r_perr;
    w_ferr_nxt    = r_ferr;
    if (s_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            w_state_nxt = START;
            w_tick_nxt  = '0;
          end
        end
        START: begin
          if (r_tick_cnt == c_mid) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx ? IDLE : DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_tick_cnt == c_last) begin
            w_tick_nxt  = '0;
            w_shreg_nxt = {w_rx, r_shreg[7:1]};
            if (r_bit_cnt == c_last_bit) begin
              w_bit_nxt   = '0;
              w_state_nxt = PARITY_EN ? PARITY : STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (r_tick_cnt == c_last) begin
            w_tick_nxt    = '0;
            w_par_bad_nxt = ((^w_word) ^ w_rx) != PARITY_ODD;
            w_state_nxt   = STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_tick_cnt == c_last) begin
            w_tick_nxt  = '0;
            w_data_nxt  = w_word;
            w_valid_nxt = 1'b1;
            w_perr_nxt  = PARITY_EN ? r_par_bad : 1'b0;
            w_ferr_nxt  = !w_rx;
            w_state_nxt = IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_par_bad  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shreg    <= w_shreg_nxt;
      r_par_bad  <= w_par_bad_nxt;
      r_rx_data  <= w_data_nxt;
      r_rx_valid <= w_valid_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
// ============================================================================
// Module  : tb_uart_rx_os16
// Purpose : Directed and random frame checks for uart_rx_os16 (8N1 and 8E1).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_os16;

  localparam int OS  = 16;
  localparam bit ODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       parity_err0, parity_err1;
  logic       frame_err0, frame_err1;
  logic       busy0, busy1;

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .OVERSAMPLING(OS)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .parity_err(parity_err0),
    .frame_err(frame_err0), .busy(busy0)
  );

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(ODD), .OVERSAMPLING(OS)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .parity_err(parity_err1),
    .frame_err(frame_err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Tick every fourth clock
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      div    = (div + 1) % 4;
      s_tick = (div == 0);
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (rx_valid0 === 1'b1) begin
      r.d = rx_data0; r.pe = parity_err0; r.fe = frame_err0;
      q0.push_back(r);
    end
    if (rx_valid1 === 1'b1) begin
      r.d = rx_data1; r.pe = parity_err1; r.fe = frame_err1;
      q1.push_back(r);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input int which, input logic v);
    #1;
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit pen,
                            input bit pbit, input bit stop, input int gap);
    drive(which, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      wait_ticks(OS);
    end
    if (pen) begin
      drive(which, pbit);
      wait_ticks(OS);
    end
    drive(which, stop);
    wait_ticks(OS);
    drive(which, 1'b1);
    wait_ticks(gap);
  endtask

  // Reference: parity error when the count of ones over data+parity disagrees with the mode
  function automatic rec_t model(input logic [7:0] d, input bit pen, input bit pbit, input bit stop);
    rec_t m;
    m.d  = d;
    m.pe = pen ? (((($countones(d) + int'(pbit)) % 2) != int'(ODD))) : 1'b0;
    m.fe = !stop;
    return m;
  endfunction

  task automatic expect_rec(input int which, input string tag, input rec_t e);
    rec_t r;
    int   sz;
    sz = (which == 0) ? q0.size() : q1.size();
    chk({tag, "/present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (which == 0) r = q0.pop_front();
      else            r = q1.pop_front();
      chk({tag, "/data"}, 32'(r.d), 32'(e.d));
      chk({tag, "/parity_err"}, 32'(r.pe), 32'(e.pe));
      chk({tag, "/frame_err"}, 32'(r.fe), 32'(e.fe));
    end
  endtask

  task automatic expect_empty(input int which, input string tag);
    int sz;
    sz = (which == 0) ? q0.size() : q1.size();
    chk({tag, "/no_extra"}, 32'(sz), 32'd0);
    if (which == 0) q0.delete();
    else            q1.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         pb, st;
    int         gap, k;

    // Reset state
    repeat (5) @(posedge clk);
    #2;
    chk("rst/rx_data", 32'(rx_data0), 32'h0);
    chk("rst/rx_valid", 32'(rx_valid0), 32'h0);
    chk("rst/parity_err", 32'(parity_err1), 32'h0);
    chk("rst/frame_err", 32'(frame_err0), 32'h0);
    chk("rst/busy", 32'({busy0, busy1}), 32'h0);
    @(negedge clk) reset = 1'b1;
    wait_ticks(4);

    // Basic 8N1
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 4);
    expect_rec(0, "a5", model(8'hA5, 1'b0, 1'b0, 1'b1));
    expect_empty(0, "a5");

    // Even parity: wrong then right parity bit
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 4);
    expect_rec(1, "par_bad", model(8'h03, 1'b1, 1'b1, 1'b1));
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 4);
    expect_rec(1, "par_ok", model(8'h03, 1'b1, 1'b0, 1'b1));
    expect_empty(1, "par");

    // Short low glitch is a false start
    drive(0, 1'b0);
    wait_ticks(2);
    #2;
    chk("glitch/busy_high", 32'(busy0), 32'h1);
    wait_ticks(2);
    drive(0, 1'b1);
    k = 0;
    while (busy0 === 1'b1 && k < 8) begin
      wait_ticks(1);
      #2;
      k++;
    end
    chk("glitch/busy_low", 32'(busy0), 32'h0);
    wait_ticks(20);
    expect_empty(0, "glitch");

    // Framing error then recovery
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 24);
    expect_rec(0, "ferr55", model(8'h55, 1'b0, 1'b0, 1'b0));
    expect_empty(0, "ferr55");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 4);
    expect_rec(0, "ok3c", model(8'h3C, 1'b0, 1'b0, 1'b1));
    expect_empty(0, "ok3c");

    // Reset in the middle of a frame
    drive(0, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1);
      wait_ticks(OS);
    end
    wait_ticks(2);
    #1 reset = 1'b0;
    #1;
    chk("midrst/busy", 32'(busy0), 32'h0);
    chk("midrst/valid", 32'(rx_valid0), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_ticks(40);
    expect_empty(0, "midrst");
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 4);
    expect_rec(0, "after_rst", model(8'h12, 1'b0, 1'b0, 1'b1));
    expect_empty(0, "after_rst");

    // Back-to-back frames with no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 4);
    expect_rec(0, "b2b0", model(8'h00, 1'b0, 1'b0, 1'b1));
    expect_rec(0, "b2b1", model(8'hFF, 1'b0, 1'b0, 1'b1));
    expect_rec(0, "b2b2", model(8'h81, 1'b0, 1'b0, 1'b1));
    expect_empty(0, "b2b");

    // Break: line low for two full frames (stop samples fall inside the low span)
    drive(0, 1'b0);
    wait_ticks(312);
    drive(0, 1'b1);
    wait_ticks(30);
    expect_rec(0, "break0", model(8'h00, 1'b0, 1'b0, 1'b0));
    expect_rec(0, "break1", model(8'h00, 1'b0, 1'b0, 1'b0));
    expect_empty(0, "break");

    // Random frames on both receivers
    for (int n = 0; n < 8; n++) begin
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) != 0);
      gap = st ? int'($urandom_range(1, 6)) : 24;
      send_frame(0, d, 1'b0, 1'b0, st, gap);
      expect_rec(0, "rnd8n1", model(d, 1'b0, 1'b0, st));
      d   = 8'($urandom_range(0, 255));
      pb  = bit'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) != 0);
      gap = st ? int'($urandom_range(1, 6)) : 24;
      send_frame(1, d, 1'b1, pb, st, gap);
      expect_rec(1, "rnd8e1", model(d, 1'b1, pb, st));
    end
    expect_empty(0, "rnd8n1");
    expect_empty(1, "rnd8e1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
